axi_rd_burst_slave: RTL and testbench

- AXI4 read-side slave stage that consumes ar_chan_t and produces r_chan_t, using the shared AXI channel types (64-bit addr/data, 4-bit ID).
- Expands each AR burst (FIXED/INCR/WRAP) into per-beat requests on a simple fixed-latency SRAM read port.
- Returns beats through a 2-entry R buffer with credit-based issue, so full throughput is kept under backpressure.
- Sits between the interconnect's AR/R channels and on-chip memory.

---
 rtl/axi_rd_burst_slave_pkg.sv | 71 +++++++
 rtl/axi_rd_burst_slave_if.sv | 25 ++
 rtl/axi_r_buffer.sv | 54 +++++
 rtl/axi_rd_burst_slave.sv | 124 ++++++++++++
 tb/tb_axi_rd_burst_slave.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_rd_burst_slave_pkg.sv
// Shared AXI read-channel types, burst constants and beat address helpers.
// The helpers are kept free of state so write-side blocks can reuse them.
package axi_rd_burst_slave_pkg;

   typedef logic [63:0] addr_t;
   typedef logic [63:0] data_t;
   typedef logic [3:0]  id_t;
   typedef logic [7:0]  len_t;
   typedef logic [2:0]  size_t;
   typedef logic [1:0]  burst_t;
   typedef logic [1:0]  resp_t;

   localparam burst_t BURST_FIXED = 2'b00;
   localparam burst_t BURST_INCR  = 2'b01;
   localparam burst_t BURST_WRAP  = 2'b10;
   localparam burst_t BURST_RSVD  = 2'b11;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;

   localparam len_t WRAP_LEN_2  = 8'd1;
   localparam len_t WRAP_LEN_4  = 8'd3;
   localparam len_t WRAP_LEN_8  = 8'd7;
   localparam len_t WRAP_LEN_16 = 8'd15;

   typedef struct packed {
      id_t    id;
      addr_t  addr;
      len_t   len;
      size_t  size;
      burst_t burst;
   } ar_chan_t;

   typedef struct packed {
      id_t   id;
      data_t data;
      resp_t resp;
      logic  last;
   } r_chan_t;

   typedef enum logic {
      ST_IDLE,
      ST_BURST
   } state_t;

   function automatic addr_t beat_bytes(size_t size);
      return addr_t'(1) << size;
   endfunction

   function automatic logic wrap_len_ok(len_t len);
      return (len == WRAP_LEN_2) || (len == WRAP_LEN_4) ||
             (len == WRAP_LEN_8) || (len == WRAP_LEN_16);
   endfunction

   function automatic addr_t next_beat_addr(addr_t cur, addr_t start, len_t len,
                                            size_t size, burst_t burst);
      addr_t nb, total, boundary, nxt;
      nb       = beat_bytes(size);
      total    = (addr_t'(len) + addr_t'(1)) << size;
      boundary = start & ~(total - addr_t'(1));
      nxt      = cur + nb;
      case (burst)
         BURST_FIXED: nxt = start;
         BURST_INCR:  nxt = (cur & ~(nb - addr_t'(1))) + nb;
         BURST_WRAP:  if (nxt == boundary + total) nxt = boundary;
         default:     nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/axi_rd_burst_slave_if.sv
// AR/R channel pair plus the fixed-latency SRAM read port of the burst slave.
// Handshake: a transfer happens on a rising edge where valid && ready; valid holds its payload until then.
interface axi_rd_burst_slave_if;
   import axi_rd_burst_slave_pkg::*;

   ar_chan_t ar;
   logic     ar_valid;
   logic     ar_ready;
   r_chan_t  r;
   logic     r_valid;
   logic     r_ready;
   logic     mem_req;
   addr_t    mem_addr;
   data_t    mem_rdata;

   modport slave (
      input  ar, ar_valid, r_ready, mem_rdata,
      output ar_ready, r, r_valid, mem_req, mem_addr
   );

   modport master (
      output ar, ar_valid, r_ready, mem_rdata,
      input  ar_ready, r, r_valid, mem_req, mem_addr
   );
endinterface

// File: rtl/axi_r_buffer.sv
// Small FIFO of R beats; falls through when empty so a returning beat is
// visible in the same cycle it is pushed.
module axi_r_buffer
   import axi_rd_burst_slave_pkg::*;
#(
   parameter int Depth = 2,
   localparam int CntW = $clog2(Depth + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  r_chan_t         push_data,
   input  logic            pop,
   output r_chan_t         head,
   output logic [CntW-1:0] count,
   output logic            full,
   output logic            empty
);
   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   r_chan_t         mem_q [Depth];
   logic [PtrW-1:0] wr_q, rd_q;
   logic [CntW-1:0] cnt_q;
   logic            wr_en, rd_en;

   function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CntW'(Depth));
   assign count = cnt_q;
   assign head  = empty ? push_data : mem_q[rd_q];

   // A beat pushed and popped while empty passes straight through, never stored.
   assign wr_en = push && !(empty && pop);
   assign rd_en = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_en) wr_q <= ptr_inc(wr_q);
         if (rd_en) rd_q <= ptr_inc(rd_q);
         cnt_q <= cnt_q + CntW'(wr_en) - CntW'(rd_en);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= push_data;
   end
endmodule

// File: rtl/axi_rd_burst_slave.sv
// AXI4 read burst slave: expands AR bursts into per-beat SRAM reads and
// returns R beats through a credit-checked buffer.
module axi_rd_burst_slave
   import axi_rd_burst_slave_pkg::*;
#(
   parameter int MaxSize   = 3,
   parameter int RespDepth = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   axi_rd_burst_slave_if.slave   bus,
   output state_t                dbg_state
);
   localparam int CntW = $clog2(RespDepth + 1);
   localparam int CW   = CntW + 1;

   state_t          state_q, state_d;
   ar_chan_t        ar_q;
   addr_t           cur_q;
   len_t            beat_q;
   logic            illegal_q, inflight_q, inflight_last_q;
   logic [CntW-1:0] buf_count;
   logic            buf_full, buf_empty;
   logic            pop, push, issue, credit_ok, is_last, ar_fire, ar_illegal;
   r_chan_t         push_data, head;

   assign pop     = bus.r_valid && bus.r_ready;
   assign is_last = (beat_q == ar_q.len);
   assign ar_fire = bus.ar_valid && bus.ar_ready;

   // Buffered beats plus the one still coming back from memory must leave a slot.
   assign credit_ok = (CW'(buf_count) + CW'(inflight_q)) < (CW'(RespDepth) + CW'(pop));

   assign ar_illegal = (bus.ar.size > size_t'(MaxSize)) ||
                       (bus.ar.burst == BURST_RSVD) ||
                       ((bus.ar.burst == BURST_WRAP) && !wrap_len_ok(bus.ar.len));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      bus.ar_ready = 1'b0;
      issue        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.ar_ready = 1'b1;
            if (bus.ar_valid) state_d = ST_BURST;
         end
         ST_BURST: begin
            if (credit_ok) begin
               issue = 1'b1;
               if (is_last) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_q            <= '0;
         cur_q           <= '0;
         beat_q          <= '0;
         illegal_q       <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         inflight_q      <= issue && !illegal_q;
         inflight_last_q <= is_last;
         if (ar_fire) begin
            ar_q      <= bus.ar;
            cur_q     <= bus.ar.addr;
            beat_q    <= '0;
            illegal_q <= ar_illegal;
         end else if (issue) begin
            beat_q <= beat_q + 8'd1;
            cur_q  <= next_beat_addr(cur_q, ar_q.addr, ar_q.len, ar_q.size, ar_q.burst);
         end
      end
   end

   assign bus.mem_req  = issue && !illegal_q;
   assign bus.mem_addr = bus.mem_req ? cur_q : '0;

   // Illegal bursts never touch memory; their error beats enter the buffer at issue.
   assign push = inflight_q || (issue && illegal_q);

   always_comb begin
      push_data.id   = ar_q.id;
      push_data.data = bus.mem_rdata;
      push_data.resp = RESP_OKAY;
      push_data.last = inflight_last_q;
      if (!inflight_q) begin
         push_data.data = '0;
         push_data.resp = RESP_SLVERR;
         push_data.last = is_last;
      end
   end

   axi_r_buffer #(.Depth(RespDepth)) u_r_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (buf_count),
      .full      (buf_full),
      .empty     (buf_empty)
   );

   assign bus.r_valid = !buf_empty || push;
   assign bus.r       = bus.r_valid ? head : '0;
   assign dbg_state   = state_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) assert (!(push && buf_full && !pop));
   end
`endif
endmodule

// File: tb/tb_axi_rd_burst_slave.sv
// Bench for axi_rd_burst_slave: burst table plus hand-written backpressure,
// back-to-back, random-ready and mid-burst reset sequences.
module tb_axi_rd_burst_slave;
   import axi_rd_burst_slave_pkg::*;

   localparam int W = $bits(r_chan_t);

   typedef struct {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [63:0] ea0, ea1, ea2, ea3;
      logic        illegal;
      int          lat;
   } vec_t;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_t dbg_state;

   always #5 clk = ~clk;

   axi_rd_burst_slave_if bus();

   axi_rd_burst_slave #(.MaxSize(3), .RespDepth(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_cyc = 0;
   int          beats_seen = 0;
   int          req_seen = 0;
   logic        prev_stall = 1'b0;
   r_chan_t     prev_r;
   logic [W-1:0] exp_q[$];
   addr_t       exp_addr_q[$];
   vec_t        vecs[10];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic data_t tb_data(addr_t a);
      return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
   endfunction

   // memory model: data one cycle after the strobe, junk otherwise
   always @(posedge clk)
      bus.mem_rdata <= bus.mem_req ? tb_data(bus.mem_addr) : {$urandom, $urandom};

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) check("r_stable", {bus.r_valid, bus.r}, {1'b1, prev_r});
         prev_stall = bus.r_valid && !bus.r_ready;
         prev_r     = bus.r;
         if (bus.mem_req) begin
            req_seen++;
            if (exp_addr_q.size() == 0) check("mem_req_unexpected", bus.mem_req, 1'b0);
            else check("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
         end
         if (bus.r_valid && bus.r_ready) begin
            beats_seen++;
            if (exp_q.size() == 0) check("r_unexpected", bus.r_valid, 1'b0);
            else check("r_beat", bus.r, exp_q.pop_front());
            if (bus.r.last) last_cyc = cyc;
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic push_beat(input logic [3:0] id, input addr_t a, input logic illegal,
                            input logic last);
      r_chan_t e;
      e.id   = id;
      e.data = illegal ? '0 : tb_data(a);
      e.resp = illegal ? RESP_SLVERR : RESP_OKAY;
      e.last = last;
      exp_q.push_back(e);
      if (!illegal) exp_addr_q.push_back(a);
   endtask

   task automatic send_ar(input ar_chan_t a, output int hs);
      bus.ar       = a;
      bus.ar_valid = 1'b1;
      hs = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.ar_ready) begin
            hs = cyc;
            break;
         end
      end
      if (hs < 0) check("ar_timeout", bus.ar_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.ar_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      for (int k = 0; k < budget; k++) begin
         if (exp_q.size() == 0 && exp_addr_q.size() == 0) break;
         @(negedge clk);
      end
      check("drain", exp_q.size() + exp_addr_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic [3:0] id, logic [63:0] addr, logic [7:0] len,
                               logic [2:0] size, logic [1:0] burst, logic [63:0] ea0,
                               logic [63:0] ea1, logic [63:0] ea2, logic [63:0] ea3,
                               logic illegal, int lat);
      vec_t v;
      v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
      v.ea0 = ea0; v.ea1 = ea1; v.ea2 = ea2; v.ea3 = ea3;
      v.illegal = illegal; v.lat = lat;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string name);
      ar_chan_t a;
      addr_t    ea;
      int       hs;
      a.id = v.id; a.addr = v.addr; a.len = v.len; a.size = v.size; a.burst = v.burst;
      for (int i = 0; i <= int'(v.len); i++) begin
         case (i)
            0:       ea = v.ea0;
            1:       ea = v.ea1;
            2:       ea = v.ea2;
            default: ea = v.ea3;
         endcase
         push_beat(v.id, ea, v.illegal, i == int'(v.len));
      end
      beats_seen = 0;
      req_seen   = 0;
      send_ar(a, hs);
      wait_drain(60);
      check({name, "_beats"}, beats_seen, int'(v.len) + 1);
      check({name, "_reqs"}, req_seen, v.illegal ? 0 : int'(v.len) + 1);
      check({name, "_latency"}, last_cyc - hs, v.lat);
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: simulation did not complete");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      ar_chan_t a, a2;
      int       hs, hs2, rel;

      vecs[0] = mk(4'h5, 64'h1004, 8'd3, 3'd2, BURST_INCR,
                   64'h1004, 64'h1008, 64'h100C, 64'h1010, 1'b0, 5);
      vecs[1] = mk(4'h3, 64'h1003, 8'd1, 3'd3, BURST_INCR,
                   64'h1003, 64'h1008, 64'h0, 64'h0, 1'b0, 3);
      vecs[2] = mk(4'h7, 64'h38, 8'd3, 3'd3, BURST_WRAP,
                   64'h38, 64'h20, 64'h28, 64'h30, 1'b0, 5);
      vecs[3] = mk(4'h9, 64'h100, 8'd2, 3'd3, BURST_FIXED,
                   64'h100, 64'h100, 64'h100, 64'h0, 1'b0, 4);
      vecs[4] = mk(4'h8, 64'h44, 8'd1, 3'd2, BURST_WRAP,
                   64'h44, 64'h40, 64'h0, 64'h0, 1'b0, 3);
      vecs[5] = mk(4'hA, 64'h40, 8'd2, 3'd2, BURST_WRAP,
                   64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 3);
      vecs[6] = mk(4'hB, 64'h80, 8'd0, 3'd4, BURST_INCR,
                   64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1);
      vecs[7] = mk(4'hC, 64'h90, 8'd1, 3'd3, BURST_RSVD,
                   64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 2);
      vecs[8] = mk(4'hD, 64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, BURST_INCR,
                   64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 64'h0, 1'b0, 3);
      vecs[9] = mk(4'hE, 64'h7F0, 8'd3, 3'd2, BURST_INCR,
                   64'h7F0, 64'h7F4, 64'h7F8, 64'h7FC, 1'b0, 5);

      bus.ar       = '0;
      bus.ar_valid = 1'b0;
      bus.r_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ar_ready", bus.ar_ready, 1'b1);
      check("rst_r_valid", bus.r_valid, 1'b0);
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 64'h0);
      check("rst_r", bus.r, '0);
      check("rst_state", dbg_state, ST_IDLE);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // back-to-back single-beat bursts
      a  = '{id: 4'h1, addr: 64'h200, len: 8'd0, size: 3'd3, burst: BURST_INCR};
      a2 = '{id: 4'h2, addr: 64'h208, len: 8'd0, size: 3'd3, burst: BURST_INCR};
      push_beat(4'h1, 64'h200, 1'b0, 1'b1);
      push_beat(4'h2, 64'h208, 1'b0, 1'b1);
      send_ar(a, hs);
      send_ar(a2, hs2);
      check("b2b_ar_gap", hs2 - hs, 2);
      wait_drain(40);
      check("b2b_latency", last_cyc - hs2, 2);

      // backpressure: 8-beat INCR with r_ready low for 5 cycles
      a = '{id: 4'h6, addr: 64'h3000, len: 8'd7, size: 3'd3, burst: BURST_INCR};
      for (int i = 0; i < 8; i++) push_beat(4'h6, 64'h3000 + 64'(8 * i), 1'b0, i == 7);
      bus.r_ready = 1'b0;
      req_seen    = 0;
      beats_seen  = 0;
      send_ar(a, hs);
      repeat (5) @(posedge clk);
      #1;
      check("stall_reqs", req_seen, 2);
      check("stall_mem_req", bus.mem_req, 1'b0);
      check("stall_r_valid", bus.r_valid, 1'b1);
      check("stall_state", dbg_state, ST_BURST);
      bus.r_ready = 1'b1;
      rel = cyc;
      wait_drain(40);
      check("stall_beats", beats_seen, 8);
      check("resume_rate", last_cyc - rel, 7);

      // random r_ready over a 16-beat burst
      a = '{id: 4'h4, addr: 64'h5000, len: 8'd15, size: 3'd2, burst: BURST_INCR};
      for (int i = 0; i < 16; i++) push_beat(4'h4, 64'h5000 + 64'(4 * i), 1'b0, i == 15);
      beats_seen = 0;
      fork
         send_ar(a, hs);
         for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            bus.r_ready = 1'($urandom_range(0, 1));
         end
      join
      bus.r_ready = 1'b1;
      wait_drain(60);
      check("rand_beats", beats_seen, 16);

      // reset in the middle of a stalled burst
      a = '{id: 4'hF, addr: 64'h6000, len: 8'd7, size: 3'd3, burst: BURST_INCR};
      for (int i = 0; i < 8; i++) push_beat(4'hF, 64'h6000 + 64'(8 * i), 1'b0, i == 7);
      bus.r_ready = 1'b0;
      send_ar(a, hs);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_ar_ready", bus.ar_ready, 1'b1);
      check("midrst_r_valid", bus.r_valid, 1'b0);
      check("midrst_mem_req", bus.mem_req, 1'b0);
      check("midrst_r", bus.r, '0);
      check("midrst_state", dbg_state, ST_IDLE);
      exp_q.delete();
      exp_addr_q.delete();
      prev_stall  = 1'b0;
      bus.r_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_vec(vecs[0], "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
